// File: rtl/pe_lsu_ctrl.sv
// pe_lsu_ctrl: load/store sequencer for the RISC-V processing element.
// Walks each memory instruction through IDLE -> ADDR -> MEM -> WB -> DONE.
// It drives the PE mux/ALU selects and owns the mem_read/mem_write handshake.
// Every output is registered and is set on the transition into the state that uses it.
// Optional feature: define LSU_TIMEOUT_EN to abort a MEM phase that sees no
// mem_ack within TIMEOUT_CYCLES cycles (err_code 11).
module pe_lsu_ctrl #(
  parameter int XLEN           = 32,
  parameter int PC_INC         = 1,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [6:0]        op,
  input  logic [2:0]        funct3,
  input  logic [4:0]        rd,
  input  logic [11:0]       imm12,
  input  logic [XLEN-1:0]   rs2_val,
  input  logic [XLEN-1:0]   alu_result,
  input  logic              ALUcomplete,
  input  logic [XLEN-1:0]   PCin,
  input  logic              mem_ack,
  output logic [4:0]        ALUsel,
  output logic [1:0]        Asel,
  output logic              Bsel,
  output logic [1:0]        Osel,
  output logic              Aenable,
  output logic              Benable,
  output logic [XLEN-1:0]   immvalue,
  output logic              mem_read,
  output logic              mem_write,
  output logic [XLEN-1:0]   mem_address,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [1:0]        mem_size,
  output logic [4:0]        rdOut,
  output logic              rdWrite,
  output logic [XLEN-1:0]   PCout,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_FUNCT3  = 2'b01;
  localparam logic [1:0] ERR_ALIGN   = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  typedef enum logic [2:0] {IDLE, ADDR, MEM, WB, DONE} state_t;

  state_t          state;
  logic            is_load;
  logic [2:0]      f3_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] rs2_q;

`ifdef LSU_TIMEOUT_EN
  // Counter is at least 8 bits wide, wider if TIMEOUT_CYCLES needs it.
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] to_cnt;
`endif

  // Loads accept every size/sign encoding except 011/110/111; stores take only 000/001/010.
  function automatic logic f3_legal(input logic load, input logic [2:0] f3);
    if (load) f3_legal = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
                         (f3 == 3'b100) || (f3 == 3'b101);
    else      f3_legal = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
  endfunction

  // Halfwords need an even address and words need a 4-byte-aligned address.
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b01:   misaligned = a[0];
      2'b10:   misaligned = (a != 2'b00);
      default: misaligned = 1'b0;
    endcase
  endfunction

  // Selects the ALU extend operation that shapes the bus data for writeback.
  function automatic logic [4:0] wb_alusel(input logic [2:0] f3);
    case (f3)
      3'b001:  wb_alusel = 5'b10001;
      3'b100:  wb_alusel = 5'b10010;
      3'b101:  wb_alusel = 5'b10011;
      default: wb_alusel = 5'b10000;
    endcase
  endfunction

  // Store data is right-aligned and zero-filled above the access size.
  function automatic logic [XLEN-1:0] align_wdata(input logic [2:0] f3, input logic [XLEN-1:0] d);
    case (f3[1:0])
      2'b00:   align_wdata = {{(XLEN-8){1'b0}}, d[7:0]};
      2'b01:   align_wdata = {{(XLEN-16){1'b0}}, d[15:0]};
      default: align_wdata = d;
    endcase
  endfunction

  // Sequencer: state transitions and registered outputs for the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      is_load     <= 1'b0;
      f3_q        <= '0;
      rd_q        <= '0;
      rs2_q       <= '0;
      ALUsel      <= '0;
      Asel        <= '0;
      Bsel        <= 1'b0;
      Osel        <= '0;
      Aenable     <= 1'b0;
      Benable     <= 1'b0;
      immvalue    <= '0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_address <= '0;
      mem_wdata   <= '0;
      mem_size    <= '0;
      rdOut       <= '0;
      rdWrite     <= 1'b0;
      PCout       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      err_code    <= ERR_NONE;
`ifdef LSU_TIMEOUT_EN
      to_cnt      <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start && (op == OP_LOAD || op == OP_STORE)) begin
            is_load <= (op == OP_LOAD);
            f3_q    <= funct3;
            rd_q    <= rd;
            rs2_q   <= rs2_val;
            busy    <= 1'b1;
            if (!f3_legal(op == OP_LOAD, funct3)) begin
              state    <= DONE;
              done     <= 1'b1;
              err      <= 1'b1;
              err_code <= ERR_FUNCT3;
              PCout    <= PCin + XLEN'(PC_INC);
            end else begin
              state    <= ADDR;
              Asel     <= 2'b00;
              Bsel     <= 1'b1;
              immvalue <= {{(XLEN-12){imm12[11]}}, imm12};
              ALUsel   <= 5'b00000;
              Osel     <= 2'b00;
              Aenable  <= 1'b1;
              Benable  <= 1'b1;
            end
          end
        end
        ADDR: begin
          if (ALUcomplete) begin
            mem_address <= alu_result;
            Aenable     <= 1'b0;
            Benable     <= 1'b0;
            if (misaligned(f3_q, alu_result[1:0])) begin
              state    <= DONE;
              done     <= 1'b1;
              err      <= 1'b1;
              err_code <= ERR_ALIGN;
              PCout    <= PCin + XLEN'(PC_INC);
            end else begin
              state     <= MEM;
              mem_read  <= is_load;
              mem_write <= !is_load;
              mem_size  <= f3_q[1:0];
              mem_wdata <= is_load ? '0 : align_wdata(f3_q, rs2_q);
`ifdef LSU_TIMEOUT_EN
              to_cnt    <= '0;
`endif
            end
          end
        end
        MEM: begin
          if (mem_ack) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            if (is_load) begin
              state   <= WB;
              Asel    <= 2'b01;
              Aenable <= 1'b1;
              ALUsel  <= wb_alusel(f3_q);
              Osel    <= (f3_q == 3'b010) ? 2'b01 : 2'b00;
              rdOut   <= rd_q;
              rdWrite <= (rd_q != 5'd0);
            end else begin
              state    <= DONE;
              done     <= 1'b1;
              err      <= 1'b0;
              err_code <= ERR_NONE;
              PCout    <= PCin + XLEN'(PC_INC);
            end
          end
`ifdef LSU_TIMEOUT_EN
          else if (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            state     <= DONE;
            done      <= 1'b1;
            err       <= 1'b1;
            err_code  <= ERR_TIMEOUT;
            PCout     <= PCin + XLEN'(PC_INC);
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
`endif
        end
        WB: begin
          Aenable  <= 1'b0;
          rdWrite  <= 1'b0;
          state    <= DONE;
          done     <= 1'b1;
          err      <= 1'b0;
          err_code <= ERR_NONE;
          PCout    <= PCin + XLEN'(PC_INC);
        end
        DONE: begin
          done     <= 1'b0;
          err      <= 1'b0;
          err_code <= ERR_NONE;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/pe_lsu_ctrl.md
# pe_lsu_ctrl

Parametrised load/store sequencer for the RISC-V processing element. It succeeds the single-cycle load controller with an explicit state machine that handles both loads (LB/LH/LW/LBU/LHU) and stores (SB/SH/SW). It adds alignment checking, error reporting, a busy/done handshake and an optional memory-timeout watchdog. It sits between the instruction decoder and the PE datapath: it drives the A/B/output mux selects, ALU select and register enables, and it owns the memory request/acknowledge handshake on the bus.

## Interface
Parameters:
- XLEN, 32, datapath, address and PC width.
- PC_INC, 1, amount added to PCin on instruction completion.
- TIMEOUT_CYCLES, 255, MEM-state cycles without mem_ack before abort; used only with LSU_TIMEOUT_EN.

Ports:
- clk  in  1  sole clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  decoded instruction valid; sampled only in IDLE.
- op  in  7  opcode: 0000011 is load, 0100011 is store.
- funct3  in  3  access size/sign.
- rd  in  5  load destination register.
- imm12  in  12  I-type (load) or S-type (store) immediate, pre-assembled by the decoder.
- rs2_val  in  XLEN  store data.
- alu_result  in  XLEN  ALU output (effective address).
- ALUcomplete  in  1  ALU result valid.
- PCin  in  XLEN  current PC.
- mem_ack  in  1  memory access complete.
- ALUsel  out  5  ALU operation select.
- Asel  out  2  A mux: 00 rs1, 01 bus data.
- Bsel  out  1  B mux: 0 rs2, 1 immvalue.
- Osel  out  2  output mux: 00 ALU, 01 reg A.
- Aenable, Benable  out  1 each  operand register enables.
- immvalue  out  XLEN  sign-extended imm12.
- mem_read, mem_write  out  1 each  memory request strobes.
- mem_address  out  XLEN  latched effective address.
- mem_wdata  out  XLEN  store data, right-aligned.
- mem_size  out  2  00 byte, 01 half, 10 word.
- rdOut  out  5  writeback register address.
- rdWrite  out  1  writeback strobe.
- PCout  out  XLEN  next PC.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with done; high if the instruction aborted.
- err_code  out  2  00 none, 01 illegal funct3, 10 misaligned, 11 timeout.

## Operation
- States: IDLE, ADDR, MEM, WB, DONE. All outputs are registered.
- IDLE: all strobes are low. When start=1 and op is a load or store, the block latches op, funct3, rd, imm12 and rs2_val.
  - Legal funct3: load 000/001/010/100/101; store 000/001/010. Any other funct3 goes to DONE with err_code=01 and no memory access.
  - A legal funct3 goes to ADDR.
  - start with any other op is ignored. start is ignored whenever busy=1.
- ADDR: Asel=00, Bsel=1, immvalue=sign-extended imm12, ALUsel=00000, Osel=00, Aenable=Benable=1.
  - On ALUcomplete the block latches mem_address=alu_result and checks alignment.
  - Misalignment (half with addr[0]=1, word with addr[1:0]≠0) goes to DONE with err_code=10.
  - An aligned address goes to MEM.
- MEM: Aenable=Benable=0. mem_read=1 (load) or mem_write=1 (store).
  - mem_address, mem_wdata and mem_size stay stable until mem_ack.
  - On mem_ack the strobe drops next cycle. A load goes to WB; a store goes to DONE.
- WB (loads only): Asel=01, Aenable=1.
  - ALUsel per funct3: LB 10000, LH 10001, LBU 10010, LHU 10011, LW 10000.
  - Osel=00, except LW uses Osel=01.
  - rdOut=rd. rdWrite=1 unless rd=0.
- DONE: done=1, err and err_code valid, PCout=PCin+PC_INC (modulo 2^XLEN, also on error). Returns to IDLE next cycle.
- mem_ack is ignored outside MEM. ALUcomplete is ignored outside ADDR.

## Timing
- Reset values: every output 0, state IDLE. Reset mid-access drops mem_read/mem_write immediately.
- Minimum load latency: start at edge 0, ALUcomplete in cycle 1, mem_ack in cycle 2, WB in cycle 3, done in cycle 4.
- Minimum store latency: done in cycle 3.
- Illegal funct3: done in cycle 1.
- The earliest accepted mem_ack is the first cycle the request strobe is high.
- A new start is accepted in the cycle after done.

## Configuration
- LSU_TIMEOUT_EN defined:
  - An 8-or-wider counter (sized from TIMEOUT_CYCLES) clears on entry to MEM and increments each MEM cycle without mem_ack.
  - When it reaches TIMEOUT_CYCLES, the strobe drops and the block goes to DONE with err_code=11 and no rdWrite.
- LSU_TIMEOUT_EN undefined: MEM waits indefinitely, err_code 11 is never produced, and TIMEOUT_CYCLES is unused.

## Test plan
- LB with imm12=0xFFC, alu_result=0x100, ack after 3 cycles → mem_read high 3 cycles, mem_size=00, WB ALUsel=10000, rdWrite=1, done with err=0, PCout=PCin+1.
- SW with alu_result=0x204, rs2_val=0xDEADBEEF → mem_write=1, mem_wdata=0xDEADBEEF, mem_size=10, no rdWrite, done at cycle 3 with zero-wait ack.
- LH at alu_result=0x101 → no mem_read, done with err_code=10. Load funct3=011 → done in cycle 1 with err_code=01.
- Assert rst during MEM with mem_read=1 → all outputs 0 at once; a later start runs normally.
- LSU_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack → mem_read high exactly 4 cycles, then done with err_code=11. Without the macro the request is held for 100 cycles.
- LW with rd=0 → rdWrite=0. start pulsed while busy → ignored, and only one done is produced.
